// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults for the system control register file.
//   - default geometry (data width, address width, depth)
//   - named addresses of the exported ALU / UART / divider registers
//   - default reset image and read-only mask for a 16-entry bank
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH      = 16;

  // Exported configuration registers, lowest addresses first
  localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_ALU_OPA   = 4'd0;
  localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_ALU_OPB   = 4'd1;
  localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_UART_CFG  = 4'd2;
  localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_DIV_RATIO = 4'd3;

  // reg2 (UART config) = 0x81, reg3 (divider ratio) = 0x20, rest 0
  localparam logic [DEF_DEPTH*DEF_DATA_WIDTH-1:0] DEF_RESET_VALUES =
    {96'h0, 8'h20, 8'h81, 16'h0};

  localparam logic [DEF_DEPTH-1:0] DEF_RO_MASK = '0;

endpackage

// File: rtl/reg_file_wr_arb.sv
// reg_file_wr_arb: combinational arbitration of bus and hardware write ports.
//   bus_en/bus_addr/bus_data : bus write request (already qualified by caller)
//   hw_en/hw_addr/hw_data    : hardware status-write request
//   we[i], wdata[i]          : per-register write enable and data
//   bus_err                  : bus write was rejected (out of range or read-only)
module reg_file_wr_arb #(
  parameter int                DATA_WIDTH = 8,
  parameter int                ADDR_WIDTH = 4,
  parameter int                DEPTH      = 16,
  parameter logic [DEPTH-1:0]  RO_MASK    = '0
) (
  input  logic                                bus_en,
  input  logic [ADDR_WIDTH-1:0]               bus_addr,
  input  logic [DATA_WIDTH-1:0]               bus_data,
  input  logic                                hw_en,
  input  logic [ADDR_WIDTH-1:0]               hw_addr,
  input  logic [DATA_WIDTH-1:0]               hw_data,
  output logic [DEPTH-1:0]                    we,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0]    wdata,
  output logic                                bus_err
);

  logic [DEPTH-1:0] bus_hit;
  logic [DEPTH-1:0] hw_hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    // RO registers never see a bus hit, so the hardware write falls through
    assign bus_hit[i] = bus_en && (bus_addr == ADDR_WIDTH'(i)) && !RO_MASK[i];
    assign hw_hit[i]  = hw_en  && (hw_addr  == ADDR_WIDTH'(i));
    assign we[i]      = bus_hit[i] | hw_hit[i];
    assign wdata[i]   = bus_hit[i] ? bus_data : hw_data;
  end

  // A bus write that landed nowhere was either out of range or read-only
  assign bus_err = bus_en && !(|bus_hit);

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: parameterised configuration/status register file.
//   CLK, RST (async, active low)
//   bus port : WrEn/RdEn/Address/WrData -> RdData, RdData_Valid (1-cycle latency)
//   hw port  : HwWrEn/HwAddress/HwWrData, ignores RO_MASK, drops out-of-range
//   Err      : registered strobe for rejected bus writes and out-of-range reads
//   REG_EXPORT / REG_UPD : live contents and change strobes of regs 0..NUM_EXPORT-1
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_EXPORT = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] RESET_VALUES = (DEPTH*DATA_WIDTH)'(DEF_RESET_VALUES),
  parameter logic [DEPTH-1:0]            RO_MASK      = DEPTH'(DEF_RO_MASK)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [DATA_WIDTH-1:0]            WrData,
  input  logic [ADDR_WIDTH-1:0]            Address,
  input  logic                             WrEn,
  input  logic                             RdEn,
  output logic [DATA_WIDTH-1:0]            RdData,
  output logic                             RdData_Valid,
  output logic                             Err,
  input  logic                             HwWrEn,
  input  logic [ADDR_WIDTH-1:0]            HwAddress,
  input  logic [DATA_WIDTH-1:0]            HwWrData,
  output logic [NUM_EXPORT*DATA_WIDTH-1:0] REG_EXPORT,
  output logic [NUM_EXPORT-1:0]            REG_UPD
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0]                 we;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] wdata;
  logic                             wr_err;
  logic                             rd_req;
  logic                             rd_in_range;
  logic [DATA_WIDTH-1:0]            rd_mux;

  reg_file_wr_arb #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .RO_MASK    (RO_MASK)
  ) u_wr_arb (
    .bus_en   (WrEn),
    .bus_addr (Address),
    .bus_data (WrData),
    .hw_en    (HwWrEn),
    .hw_addr  (HwAddress),
    .hw_data  (HwWrData),
    .we       (we),
    .wdata    (wdata),
    .bus_err  (wr_err)
  );

  // Write beats read: a combined request is a pure write
  assign rd_req      = RdEn && !WrEn;
  assign rd_in_range = {1'b0, Address} < (ADDR_WIDTH+1)'(DEPTH);

  // Read mux over implemented registers only; unmapped addresses read 0
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++)
      if (Address == ADDR_WIDTH'(i)) rd_mux = regs[i];
  end

  // Storage
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      regs <= RESET_VALUES;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (we[i]) regs[i] <= wdata[i];
    end
  end

  // Read port and error strobe; reads sample the pre-edge contents
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RdData       <= '0;
      RdData_Valid <= 1'b0;
      Err          <= 1'b0;
    end else begin
      RdData_Valid <= rd_req;
      RdData       <= (rd_req && rd_in_range) ? rd_mux : '0;
      Err          <= wr_err || (rd_req && !rd_in_range);
    end
  end

  // Change strobes compare new data against the value being replaced
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      REG_UPD <= '0;
    end else begin
      for (int k = 0; k < NUM_EXPORT; k++)
        REG_UPD[k] <= we[k] && (wdata[k] != regs[k]);
    end
  end

  assign REG_EXPORT = regs[NUM_EXPORT-1:0];

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 12;
  localparam int NE = 4;
  localparam logic [DP*DW-1:0] RV = {64'h0, 8'h20, 8'h81, 16'h0};
  localparam logic [DP-1:0]    RO = 12'h020;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] WrData = '0;
  logic [AW-1:0] Address = '0;
  logic          WrEn = 1'b0;
  logic          RdEn = 1'b0;
  logic [DW-1:0] RdData;
  logic          RdData_Valid;
  logic          Err;
  logic          HwWrEn = 1'b0;
  logic [AW-1:0] HwAddress = '0;
  logic [DW-1:0] HwWrData = '0;
  logic [NE*DW-1:0] REG_EXPORT;
  logic [NE-1:0]    REG_UPD;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e;

  always #5 CLK = ~CLK;

  reg_file_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .NUM_EXPORT(NE),
    .RESET_VALUES(RV), .RO_MASK(RO)
  ) dut (
    .CLK(CLK), .RST(RST), .WrData(WrData), .Address(Address), .WrEn(WrEn),
    .RdEn(RdEn), .RdData(RdData), .RdData_Valid(RdData_Valid), .Err(Err),
    .HwWrEn(HwWrEn), .HwAddress(HwAddress), .HwWrData(HwWrData),
    .REG_EXPORT(REG_EXPORT), .REG_UPD(REG_UPD)
  );

  // One clocked access: drive on negedge, return 1 time unit after posedge
  task automatic cyc(input logic wr, input logic rd, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic hw,
                     input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    @(negedge CLK);
    WrEn = wr; RdEn = rd; Address = a; WrData = d;
    HwWrEn = hw; HwAddress = ha; HwWrData = hd;
    @(posedge CLK);
    #1;
    WrEn = 0; RdEn = 0; HwWrEn = 0;
  endtask

  // Bus read with scoreboard: expectation queued at issue, popped on valid
  task automatic rd_chk(input logic [AW-1:0] a, input logic [DW-1:0] x, input string nm);
    exp_q.push_back(x);
    cyc(0, 1, a, 0, 0, 0, 0);
    n_cmp++;
    if (RdData_Valid !== 1'b1) begin
      n_bad++; $display("FAIL %s valid: got %b want 1", nm, RdData_Valid);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (RdData !== e) begin
        n_bad++; $display("FAIL %s data: got %h want %h", nm, RdData, e);
      end
    end
  endtask

  task automatic test_reset();
    RST = 0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (REG_EXPORT !== 32'h2081_0000) begin
      n_bad++; $display("FAIL reset_export: got %h want 20810000", REG_EXPORT);
    end
    n_cmp++;
    if ({RdData, RdData_Valid, Err, REG_UPD} !== '0) begin
      n_bad++; $display("FAIL reset_strobes: got %h/%b/%b/%b want 0", RdData, RdData_Valid, Err, REG_UPD);
    end
    @(negedge CLK);
    RST = 1;
  endtask

  task automatic test_write_read();
    cyc(1, 0, 1, 8'h5A, 0, 0, 0);
    n_cmp++;
    if (REG_UPD !== 4'b0010) begin
      n_bad++; $display("FAIL wr_upd: got %b want 0010", REG_UPD);
    end
    n_cmp++;
    if (REG_EXPORT[15:8] !== 8'h5A || Err !== 1'b0) begin
      n_bad++; $display("FAIL wr_export: got %h err %b want 5a err 0", REG_EXPORT[15:8], Err);
    end
    rd_chk(1, 8'h5A, "rd_after_wr");
    n_cmp++;
    if (REG_UPD !== 4'b0000) begin
      n_bad++; $display("FAIL upd_one_cycle: got %b want 0000", REG_UPD);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (RdData_Valid !== 1'b0 || RdData !== '0) begin
      n_bad++; $display("FAIL idle: got valid %b data %h want 0/00", RdData_Valid, RdData);
    end
  endtask

  task automatic test_read_only();
    cyc(1, 0, 5, 8'hFF, 0, 0, 0);
    n_cmp++;
    if (Err !== 1'b1) begin
      n_bad++; $display("FAIL ro_err: got %b want 1", Err);
    end
    rd_chk(5, 8'h00, "ro_keeps_reset");
    cyc(0, 0, 0, 0, 1, 5, 8'h33);
    n_cmp++;
    if (Err !== 1'b0) begin
      n_bad++; $display("FAIL hw_ro_err: got %b want 0", Err);
    end
    rd_chk(5, 8'h33, "hw_ro_write");
  endtask

  task automatic test_collision();
    cyc(1, 0, 1, 8'h11, 1, 1, 8'h22);
    n_cmp++;
    if (Err !== 1'b0 || REG_EXPORT[15:8] !== 8'h11) begin
      n_bad++; $display("FAIL coll_rw: got %h err %b want 11 err 0", REG_EXPORT[15:8], Err);
    end
    cyc(1, 0, 5, 8'h11, 1, 5, 8'h22);
    n_cmp++;
    if (Err !== 1'b1) begin
      n_bad++; $display("FAIL coll_ro_err: got %b want 1", Err);
    end
    rd_chk(5, 8'h22, "coll_ro_hw_wins");
    cyc(1, 0, 0, 8'h44, 1, 6, 8'h55);
    n_cmp++;
    if (REG_UPD !== 4'b0001 || Err !== 1'b0) begin
      n_bad++; $display("FAIL dual_upd: got %b err %b want 0001 err 0", REG_UPD, Err);
    end
    rd_chk(0, 8'h44, "dual_bus");
    rd_chk(6, 8'h55, "dual_hw");
    // Read and hw write to same register: pre-edge value returned
    exp_q.push_back(8'h55);
    cyc(0, 1, 6, 0, 1, 6, 8'h66);
    e = exp_q.pop_front();
    n_cmp++;
    if (RdData_Valid !== 1'b1 || RdData !== e) begin
      n_bad++; $display("FAIL rd_hw_coll: got %b/%h want 1/%h", RdData_Valid, RdData, e);
    end
    rd_chk(6, 8'h66, "rd_hw_coll_after");
  endtask

  task automatic test_out_of_range();
    exp_q.push_back(8'h00);
    cyc(0, 1, 14, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if (RdData_Valid !== 1'b1 || RdData !== e || Err !== 1'b1) begin
      n_bad++; $display("FAIL oor_read: got %b/%h/%b want 1/%h/1", RdData_Valid, RdData, Err, e);
    end
    cyc(1, 0, 13, 8'hAA, 0, 0, 0);
    n_cmp++;
    if (Err !== 1'b1) begin
      n_bad++; $display("FAIL oor_write_err: got %b want 1", Err);
    end
    cyc(0, 0, 0, 0, 1, 14, 8'hBB);
    n_cmp++;
    if (Err !== 1'b0 || REG_UPD !== 4'b0000) begin
      n_bad++; $display("FAIL oor_hw_silent: got err %b upd %b want 0/0000", Err, REG_UPD);
    end
    cyc(1, 1, 7, 8'h77, 0, 0, 0);
    n_cmp++;
    if (RdData_Valid !== 1'b0 || Err !== 1'b0) begin
      n_bad++; $display("FAIL wr_prio: got valid %b err %b want 0/0", RdData_Valid, Err);
    end
    rd_chk(7, 8'h77, "wr_prio_data");
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 8, 8'h01, 0, 0, 0);
    cyc(1, 0, 9, 8'h02, 0, 0, 0);
    rd_chk(8, 8'h01, "b2b_8");
    rd_chk(9, 8'h02, "b2b_9");
    rd_chk(0, 8'h44, "b2b_0");
    rd_chk(1, 8'h11, "b2b_1");
    rd_chk(2, 8'h81, "b2b_2");
    rd_chk(3, 8'h20, "b2b_3");
  endtask

  task automatic test_unchanged();
    cyc(1, 0, 0, 8'h44, 0, 0, 0);
    n_cmp++;
    if (REG_UPD !== 4'b0000 || Err !== 1'b0) begin
      n_bad++; $display("FAIL same_val_upd: got %b err %b want 0000/0", REG_UPD, Err);
    end
    cyc(0, 0, 0, 0, 1, 2, 8'h81);
    n_cmp++;
    if (REG_UPD !== 4'b0000) begin
      n_bad++; $display("FAIL same_val_hw_upd: got %b want 0000", REG_UPD);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    RdEn = 1; Address = 1;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (RdData_Valid !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre_valid: got %b want 1", RdData_Valid);
    end
    #1;
    RST = 0;
    #1;
    n_cmp++;
    if (RdData_Valid !== 1'b0 || RdData !== '0) begin
      n_bad++; $display("FAIL mid_rst_out: got %b/%h want 0/00", RdData_Valid, RdData);
    end
    n_cmp++;
    if (REG_EXPORT !== 32'h2081_0000) begin
      n_bad++; $display("FAIL mid_rst_regs: got %h want 20810000", REG_EXPORT);
    end
    RdEn = 0;
    @(negedge CLK);
    RST = 1;
    rd_chk(8, 8'h00, "post_rst_reg8");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_only();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_unchanged();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised configuration/status register file for the system control path. It generalises the 16×8 register bank in depth, width and number of exported registers, and makes per-register reset values a parameter. It adds a read-only mask, a hardware status-write port, an error strobe and per-export update strobes. Software access comes from the system controller; the exported registers drive ALU, UART and clock-divider configuration.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each register and of the data buses.
- ADDR_WIDTH, 4, width of both address buses.
- DEPTH, 16, number of implemented registers. Legal range is 1 to 2^ADDR_WIDTH.
- NUM_EXPORT, 4, number of registers exported, starting at address 0. Legal range is 1 to DEPTH.
- RESET_VALUES, DEPTH*DATA_WIDTH bits, packed reset values with register i at bits [i*DATA_WIDTH +: DATA_WIDTH]. The default is 0x81 at address 2, 0x20 at address 3, and 0 elsewhere.
- RO_MASK, DEPTH bits, where bit i set means register i is read-only to the bus port. Default is 0.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- WrData  in  DATA_WIDTH  bus write data.
- Address  in  ADDR_WIDTH  bus address.
- WrEn  in  1  bus write request.
- RdEn  in  1  bus read request.
- RdData  out  DATA_WIDTH  registered read data.
- RdData_Valid  out  1  one-cycle read-data strobe.
- Err  out  1  one-cycle error strobe.
- HwWrEn  in  1  hardware status-write request.
- HwAddress  in  ADDR_WIDTH  hardware write address.
- HwWrData  in  DATA_WIDTH  hardware write data.
- REG_EXPORT  out  NUM_EXPORT*DATA_WIDTH  live contents of registers 0 to NUM_EXPORT-1, packed like RESET_VALUES.
- REG_UPD  out  NUM_EXPORT  per-export strobe, high for one cycle when that register's value changed.

## Operation
- **Reset:**
  - Every register loads its RESET_VALUES slice.
  - RdData, RdData_Valid, Err and REG_UPD all go to 0.
- **Bus priority:** WrEn takes priority over RdEn. When both are high, only the write is performed, with no read strobe.
- **Bus write:**
  - If Address < DEPTH and RO_MASK[Address] = 0, the register is written.
  - Otherwise nothing is written and Err pulses.
- **Bus read:**
  - If Address < DEPTH: RdData takes the register value and RdData_Valid = 1.
  - If Address >= DEPTH: RdData = 0, RdData_Valid = 1, and Err = 1.
- **Idle (neither WrEn nor RdEn):** RdData = 0 and RdData_Valid = 0.
- **Hardware write:**
  - If HwAddress < DEPTH, the register is written. RO_MASK is ignored, so this port is how status registers are set.
  - If HwAddress >= DEPTH, the write is silently dropped. Err is not asserted.
- **Simultaneous bus and hardware writes, same address:**
  - If the register is RW (RO_MASK bit = 0), the bus write wins and the hardware write is dropped.
  - If the register is RO, the hardware write wins and Err still pulses for the rejected bus write.
- **Simultaneous bus and hardware writes, different addresses:** both writes take effect.
- **Read/write collision:** a bus read in the same cycle as a hardware write to that address returns the pre-edge value.
- **REG_UPD[k]:** pulses in the cycle after any write whose new value differs from the old value of register k. Rewriting the same value produces no pulse.
- **Width rules:** there is no arithmetic. Addresses are compared unsigned against DEPTH.

## Timing
- **Write latency:** a write is visible on REG_EXPORT and to bus reads from the cycle after the sampling edge.
- **Read latency:** 1 cycle. RdData and RdData_Valid are registered from the edge that samples RdEn.
- **Strobes:** Err and REG_UPD are registered, each high for exactly one cycle per event.
- **Back-to-back accesses:** accesses in consecutive cycles are supported at full rate. There is no busy or stall.
- **Reset mid-access:** an asynchronous RST during an access discards the access immediately. All outputs take their reset values without waiting for a clock edge.

## Structure
- **Package reg_file_pkg:**
  - default DATA_WIDTH, ADDR_WIDTH and DEPTH;
  - named address constants for the ALU, UART and divider registers;
  - the default RESET_VALUES and RO_MASK constants.
- **Sub-module reg_file_wr_arb:**
  - combinational arbitration between the bus and hardware write ports;
  - produces the per-register write enable, write data and bus-error signal.
- **Top level:** storage array, read register, strobe registers, export packing.

## Test plan
- **Reset values:** assert RST, then release → REG_EXPORT shows reg2 = 0x81 and reg3 = 0x20, all other exports 0, and every output strobe 0.
- **Write then read:** write 0x5A to address 1, then read address 1 on the next cycle → RdData = 0x5A with RdData_Valid for one cycle, and REG_UPD[1] pulses one cycle after the write.
- **Read-only register (RO_MASK bit 5 set):**
  - Bus write 0xFF to address 5 → Err pulses and a read returns the reset value.
  - Hardware write 0x33 to address 5 → a read returns 0x33.
- **Collisions at one address:**
  - Bus 0x11 and hardware 0x22 to RW address 1 in the same cycle → the register holds 0x11.
  - The same pair to RO address 5 → the register holds 0x22 and Err pulses.
- **Out-of-range and priority (DEPTH = 12):**
  - Read address 14 → RdData = 0, RdData_Valid = 1, Err = 1.
  - WrEn and RdEn together → the write is performed and there is no RdData_Valid.
- **Unchanged rewrite and reset mid-access:**
  - Rewrite reg0 with its current value → no REG_UPD pulse.
  - Assert RST mid-read → RdData_Valid goes to 0 immediately and registers return to reset values.
